// File: rtl/result_bcd_converter.sv
// Serial 8-bit binary to 3-digit BCD converter (double dabble, one bit per cycle)
// with optional two's-complement input and leading-zero blanking.
module result_bcd_converter #(
    parameter bit LEAD_BLANK = 1'b0
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] value,
    input  logic       signed_mode,
    output logic [3:0] bcd_hundreds,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       neg,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] scratch_q, scratch_d;
    logic [7:0]  mag_q, mag_d;
    logic [2:0]  count_q, count_d;
    logic        sign_q, sign_d;
    logic [11:0] digits_q, digits_d;
    logic        neg_q, neg_d;
    logic [11:0] adj;

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Leading zeros become 4'hF; the ones digit always shows.
    function automatic logic [11:0] blank(input logic [11:0] d);
        logic [11:0] r;
        r = d;
        if (LEAD_BLANK && d[11:8] == 4'd0) begin
            r[11:8] = 4'hF;
            if (d[7:4] == 4'd0)
                r[7:4] = 4'hF;
        end
        return r;
    endfunction

    always_comb begin
        state_d   = state_q;
        scratch_d = scratch_q;
        mag_d     = mag_q;
        count_d   = count_q;
        sign_d    = sign_q;
        digits_d  = digits_q;
        neg_d     = neg_q;
        adj       = {dabble(scratch_q[11:8]), dabble(scratch_q[7:4]), dabble(scratch_q[3:0])};

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (signed_mode && value[7]) begin
                        mag_d  = ~value + 8'd1;
                        sign_d = 1'b1;
                    end else begin
                        mag_d  = value;
                        sign_d = 1'b0;
                    end
                    scratch_d = 12'd0;
                    count_d   = 3'd0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                {scratch_d, mag_d} = {adj, mag_q} << 1;
                count_d = count_q + 3'd1;
                if (count_q == 3'd7) begin
                    digits_d = blank(scratch_d);
                    // A zero magnitude never reports negative.
                    neg_d    = sign_q & (|scratch_d);
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            scratch_q <= 12'd0;
            mag_q     <= 8'd0;
            count_q   <= 3'd0;
            sign_q    <= 1'b0;
            digits_q  <= 12'd0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            scratch_q <= scratch_d;
            mag_q     <= mag_d;
            count_q   <= count_d;
            sign_q    <= sign_d;
            digits_q  <= digits_d;
            neg_q     <= neg_d;
        end
    end

    assign in_ready     = (state_q == IDLE);
    assign done         = (state_q == DONE);
    assign bcd_hundreds = digits_q[11:8];
    assign bcd_tens     = digits_q[7:4];
    assign bcd_ones     = digits_q[3:0];
    assign neg          = neg_q;

endmodule

// File: tb/tb_result_bcd_converter.sv
// Bench for result_bcd_converter: one plain and one blanking instance share stimulus
// and are checked against a decimal reference model.
module tb_result_bcd_converter;

    logic       Clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] value;
    logic       signed_mode;

    logic       rdyA, doneA, negA;
    logic [3:0] hA, tA, oA;
    logic       rdyB, doneB, negB;
    logic [3:0] hB, tB, oB;

    int tests = 0;
    int fails = 0;

    logic [12:0] heldA, heldB;

    result_bcd_converter #(.LEAD_BLANK(1'b0)) dutA (
        .Clock(Clock), .reset(reset), .in_valid(in_valid), .in_ready(rdyA),
        .value(value), .signed_mode(signed_mode),
        .bcd_hundreds(hA), .bcd_tens(tA), .bcd_ones(oA), .neg(negA), .done(doneA)
    );

    result_bcd_converter #(.LEAD_BLANK(1'b1)) dutB (
        .Clock(Clock), .reset(reset), .in_valid(in_valid), .in_ready(rdyB),
        .value(value), .signed_mode(signed_mode),
        .bcd_hundreds(hB), .bcd_tens(tB), .bcd_ones(oB), .neg(negB), .done(doneB)
    );

    wire [12:0] outA = {hA, tA, oA, negA};
    wire [12:0] outB = {hB, tB, oB, negB};

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Decimal reference: {hundreds, tens, ones, neg}.
    function automatic logic [12:0] model(input logic [7:0] v, input logic sm, input bit blk);
        int m;
        logic [3:0] h, t, o;
        bit n;
        if (sm && v[7]) begin
            m = 256 - int'(v);
            n = 1'b1;
        end else begin
            m = int'(v);
            n = 1'b0;
        end
        if (m == 0) n = 1'b0;
        h = 4'(m / 100);
        t = 4'((m / 10) % 10);
        o = 4'(m % 10);
        if (blk && h == 4'd0) begin
            h = 4'hF;
            if (t == 4'd0) t = 4'hF;
        end
        return {h, t, o, n};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT expected idle; returns at the negedge after E9.
    task automatic convert(input logic [7:0] v, input logic sm, input bit pulse);
        int guard;
        logic [12:0] ea, eb;
        guard = 0;
        while (rdyA !== 1'b1 && guard < 20) begin
            @(negedge Clock);
            guard++;
        end
        chk("ready_wait", {15'd0, rdyA}, 16'd1);
        ea = model(v, sm, 1'b0);
        eb = model(v, sm, 1'b1);
        value = v;
        signed_mode = sm;
        in_valid = 1'b1;
        @(negedge Clock);
        in_valid = 1'b0;
        value = 8'($urandom);
        signed_mode = 1'($urandom);
        for (int k = 1; k <= 8; k++) begin
            chk("shift_ready", {14'd0, rdyA, rdyB}, 16'd0);
            chk("shift_done", {14'd0, doneA, doneB}, 16'd0);
            chk("hold_A", {3'd0, outA}, {3'd0, heldA});
            chk("hold_B", {3'd0, outB}, {3'd0, heldB});
            in_valid = (pulse && k == 3);
            if (pulse && k == 3) value = 8'($urandom);
            @(negedge Clock);
        end
        in_valid = 1'b0;
        chk("done_hi", {14'd0, doneA, doneB}, 16'h3);
        chk("done_ready", {14'd0, rdyA, rdyB}, 16'd0);
        chk("result_A", {3'd0, outA}, {3'd0, ea});
        chk("result_B", {3'd0, outB}, {3'd0, eb});
        heldA = ea;
        heldB = eb;
        @(negedge Clock);
        chk("done_lo", {14'd0, doneA, doneB}, 16'd0);
        chk("idle_ready", {14'd0, rdyA, rdyB}, 16'h3);
        chk("idle_hold_A", {3'd0, outA}, {3'd0, heldA});
    endtask

    logic [7:0] vals [0:39];
    logic       sms  [0:39];

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        value = 8'd0;
        signed_mode = 1'b0;
        heldA = 13'd0;
        heldB = 13'd0;
        repeat (3) @(negedge Clock);
        chk("rst_out_A", {3'd0, outA}, 16'd0);
        chk("rst_out_B", {3'd0, outB}, 16'd0);
        chk("rst_done", {14'd0, doneA, doneB}, 16'd0);
        chk("rst_ready", {14'd0, rdyA, rdyB}, 16'h3);
        reset = 1'b1;
        @(negedge Clock);

        // Directed boundary values
        convert(8'hFF, 1'b0, 1'b0);
        chk("ff_unsigned", {3'd0, outA}, {3'd0, 4'd2, 4'd5, 4'd5, 1'b0});
        convert(8'h80, 1'b1, 1'b0);
        chk("m128", {3'd0, outA}, {3'd0, 4'd1, 4'd2, 4'd8, 1'b1});
        convert(8'hFF, 1'b1, 1'b1);
        chk("m1", {3'd0, outA}, {3'd0, 4'd0, 4'd0, 4'd1, 1'b1});
        convert(8'h7F, 1'b1, 1'b0);
        chk("p127", {3'd0, outA}, {3'd0, 4'd1, 4'd2, 4'd7, 1'b0});
        convert(8'h00, 1'b1, 1'b0);
        chk("zero", {3'd0, outA}, 16'd0);
        convert(8'h05, 1'b0, 1'b0);
        chk("blank_5", {3'd0, outB}, {3'd0, 4'hF, 4'hF, 4'd5, 1'b0});
        convert(8'h64, 1'b0, 1'b1);
        chk("blank_100", {3'd0, outB}, {3'd0, 4'd1, 4'd0, 4'd0, 1'b0});
        convert(8'h0A, 1'b0, 1'b0);
        chk("blank_10", {3'd0, outB}, {3'd0, 4'hF, 4'd1, 4'd0, 1'b0});

        // No stray done after an ignored pulse
        repeat (12) begin
            chk("no_extra_done", {14'd0, doneA, doneB}, 16'd0);
            @(negedge Clock);
        end

        // in_valid held high with fresh random data every cycle
        in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            chk("b2b_ready", {15'd0, rdyA}, {15'd0, (c % 10 == 0)});
            chk("b2b_done", {15'd0, doneA}, {15'd0, (c % 10 == 9)});
            if (c % 10 == 9) begin
                heldA = model(vals[c - 9], sms[c - 9], 1'b0);
                heldB = model(vals[c - 9], sms[c - 9], 1'b1);
            end
            chk("b2b_out_A", {3'd0, outA}, {3'd0, heldA});
            chk("b2b_out_B", {3'd0, outB}, {3'd0, heldB});
            vals[c] = 8'($urandom);
            sms[c] = 1'($urandom);
            value = vals[c];
            signed_mode = sms[c];
            @(negedge Clock);
        end
        in_valid = 1'b0;
        @(negedge Clock);

        // Reset in the middle of a conversion
        value = 8'd200;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        @(negedge Clock);
        in_valid = 1'b0;
        repeat (3) @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);
        heldA = 13'd0;
        heldB = 13'd0;
        chk("midrst_out_A", {3'd0, outA}, 16'd0);
        chk("midrst_out_B", {3'd0, outB}, 16'd0);
        chk("midrst_done", {14'd0, doneA, doneB}, 16'd0);
        reset = 1'b1;
        @(negedge Clock);
        chk("post_rst_ready", {14'd0, rdyA, rdyB}, 16'h3);
        repeat (10) begin
            chk("post_rst_no_done", {14'd0, doneA, doneB}, 16'd0);
            @(negedge Clock);
        end
        convert(8'd37, 1'b0, 1'b0);
        chk("after_rst_37", {3'd0, outA}, {3'd0, 4'd0, 4'd3, 4'd7, 1'b0});

        // Exhaustive sweep in both modes, random ignored pulses
        for (int sm = 0; sm < 2; sm++) begin
            for (int v = 0; v < 256; v++) begin
                convert(8'(v), 1'(sm), 1'($urandom_range(0, 1)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 Parameter: LEAD_BLANK, default 0, when 1 replaces leading-zero hundreds/tens digits with blank code 4'hF.
REQ-002 Clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 in_valid  input  1  a new 8-bit result is offered on value.
REQ-005 in_ready  output  1  converter is idle and accepts input this cycle.
REQ-006 value  input  8  result from the ALU output register.
REQ-007 signed_mode  input  1  when 1, value is two's complement; sampled only at accept.
REQ-008 bcd_hundreds, bcd_tens, bcd_ones  output  4 each  registered decimal digits of the last completed conversion.
REQ-009 neg  output  1  registered sign of the last completed conversion.
REQ-010 done  output  1  one-cycle pulse; the digit and neg outputs were updated on the previous edge.

Function
REQ-011 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, and SHALL drive in_ready = (state == IDLE) combinationally.
REQ-012 Accept SHALL occur on an edge where in_ready = 1 and in_valid = 1; in_valid in SHIFT or DONE SHALL be ignored, never queued.
REQ-013 At accept, the block SHALL capture the magnitude and sign:
  - signed_mode = 1 and value[7] = 1: magnitude = (~value + 1) as 8-bit unsigned (8'h80 gives 128); sign = 1.
  - otherwise: magnitude = value; sign = 0.
  - The block SHALL clear the 12-bit BCD scratch register, set iteration count = 0, and go to SHIFT.
REQ-014 Each SHIFT edge SHALL perform one double-dabble iteration:
  - add 3 to every scratch digit that is >= 5;
  - shift {scratch, magnitude} left by 1;
  - increment the count.
REQ-015 The 8th iteration edge (count == 7) SHALL:
  - load bcd_hundreds, bcd_tens, bcd_ones and neg from the final scratch value and the captured sign;
  - enter DONE.
  - Accept-to-output-update latency is exactly 8 edges.
REQ-016 done SHALL be 1 exactly during the DONE cycle; the next edge SHALL return to IDLE.
  - Throughput: one conversion per 10 cycles.
  - With in_valid held high, accepts SHALL repeat every 10 cycles.
REQ-017 Digit and neg outputs SHALL hold their values between completed conversions, including throughout SHIFT.
REQ-018 With LEAD_BLANK = 1:
  - hundreds SHALL output 4'hF when it is 0;
  - tens SHALL output 4'hF when it is 0 and hundreds is 0;
  - ones SHALL never be blanked.
REQ-019 A magnitude of 0 SHALL always produce neg = 0.
REQ-020 Maximum results: 255 unsigned (2,5,5) and 128 signed (1,2,8). No digit SHALL exceed 9 except the blank code.

Reset
REQ-021 When reset = 0 on an edge, the block SHALL apply the reset on that edge, regardless of state:
  - state = IDLE;
  - all digit outputs = 4'h0, neg = 0, done = 0;
  - scratch and count cleared.
REQ-022 Reset mid-conversion SHALL abandon the conversion with no done pulse; in_ready SHALL be 1 in the first cycle after reset is released.
REQ-023 Reset SHALL take priority over an accept on the same edge.

Verification
REQ-024 Unsigned max: value = 8'hFF, signed_mode = 0, accepted at edge E0 -> at edge E8 outputs are 2,5,5 with neg = 0; done = 1 only in the E8–E9 cycle; in_ready = 0 from E0 to E9.
REQ-025 Signed extremes:
  - 8'h80, signed_mode = 1 -> 1,2,8, neg = 1.
  - 8'hFF, signed_mode = 1 -> 0,0,1, neg = 1.
  - 8'h7F, signed_mode = 1 -> 1,2,7, neg = 0.
REQ-026 Zero and blanking:
  - 8'h00, signed_mode = 1 -> 0,0,0, neg = 0.
  - With LEAD_BLANK = 1: 8'h05 -> F,F,5; 8'h64 -> 1,0,0; 8'h0A -> F,1,0.
REQ-027 Back-to-back and ignore:
  - in_valid held high with value changing every cycle -> accepts every 10 cycles, each converting the value present at its accept edge.
  - A pulse on in_valid during SHIFT -> ignored, no extra done.
REQ-028 Reset mid-operation:
  - Accept 8'd200, assert reset at E4 -> no done; outputs 0,0,0 with neg = 0; in_ready = 1 after release.
  - A new accept of 8'd37 then yields 0,3,7.
REQ-029 Exhaustive sweep: all 256 values in both modes, compared against a decimal reference model, including the hold of outputs during SHIFT.
